axis_pkt_gen: RTL

AXI4-Stream packet transmitter: on a start pulse it emits one packet of `pkt_len` words on its master interface, with the word sequence `seed + k*step`, TLAST on the final beat, and full TREADY backpressure handling. It is the traffic source for the stream-processing blocks (word-buffering sinks such as the integer pipeline). It replaces the DMA MM2S channel in bench and bring-up builds.

---
 rtl/axis_pkg.sv | 38 +++
 rtl/axis_pkt_gen_if.sv | 15 +
 rtl/axis_pkt_gen.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/axis_pkg.sv
// Shared definitions for the AXI4-Stream packet generator.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
// Contents: clogb2() sizing helper, FSM state encoding and the packet counter width.
// The CSUM state exists only when AXIS_PKT_GEN_CHECKSUM_EN is defined.
package axis_pkg;

   localparam int PKT_COUNT_WIDTH = 16;

   // Ceiling log2, used for sizing. clogb2(8) = 3.
   function automatic int clogb2(input int value);
      int v;
      int r;
      v = value - 1;
      r = 0;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

`ifdef AXIS_PKT_GEN_CHECKSUM_EN
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      CSUM = 2'd2,
      DONE = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd3
   } state_t;
`endif

endpackage

// File: rtl/axis_pkt_gen_if.sv
// AXI4-Stream bundle (TVALID/TDATA/TLAST/TREADY) used by the packet generator.
// Latency: none, wires only.
// Backpressure: ready flows from the slave back to the master.
// Ports: valid, data[DATA_WIDTH], last driven by the master; ready driven by the slave.
interface axis_pkt_gen_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  valid;
   logic [DATA_WIDTH-1:0] data;
   logic                  last;
   logic                  ready;

   modport master (output valid, output data, output last, input ready);
   modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/axis_pkt_gen.sv
// AXI4-Stream packet source: one packet of seed + k*step words per accepted start.
// Latency: first beat one cycle after start; one beat per cycle while ready; done one cycle after last handshake.
// Backpressure: holds the current beat (valid/data/last) while ready is low, indefinitely.
// Ports: axi_clk, axi_reset (sync, active-high), start/pkt_len/seed/step (request),
//        m_axis (master stream), busy, done (pulse), pkt_count (completed packets, wraps).
// Option: AXIS_PKT_GEN_CHECKSUM_EN appends an XOR-of-payload beat carrying last.
module axis_pkt_gen
   import axis_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int MAX_WORDS  = 8
) (
   input  logic                       axi_clk,
   input  logic                       axi_reset,
   input  logic                       start,
   input  logic [clogb2(MAX_WORDS):0] pkt_len,
   input  logic [DATA_WIDTH-1:0]      seed,
   input  logic [DATA_WIDTH-1:0]      step,
   axis_pkt_gen_if.master             m_axis,
   output logic                       busy,
   output logic                       done,
   output logic [PKT_COUNT_WIDTH-1:0] pkt_count
);

   localparam int LW = clogb2(MAX_WORDS) + 1;
   localparam logic [LW-1:0] MAX_LEN = LW'(MAX_WORDS);
   localparam logic [LW-1:0] ONE     = LW'(1);

   state_t                     state_q, state_n;
   logic [LW-1:0]              cnt_q, cnt_n;
   logic [LW-1:0]              len_q, len_n;
   logic [DATA_WIDTH-1:0]      step_q, step_n;
   logic [DATA_WIDTH-1:0]      data_q, data_n;
   logic                       valid_q, valid_n;
   logic                       last_q, last_n;
   logic                       busy_q, busy_n;
   logic                       done_q, done_n;
   logic [PKT_COUNT_WIDTH-1:0] pcnt_q, pcnt_n;
`ifdef AXIS_PKT_GEN_CHECKSUM_EN
   logic [DATA_WIDTH-1:0]      csum_q, csum_n;
`endif

   logic [LW-1:0] len_eff;
   logic          hs;
   logic          final_beat;

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      len_n   = len_q;
      step_n  = step_q;
      data_n  = data_q;
      valid_n = valid_q;
      last_n  = last_q;
      busy_n  = busy_q;
      done_n  = 1'b0;
      pcnt_n  = pcnt_q;
`ifdef AXIS_PKT_GEN_CHECKSUM_EN
      csum_n  = csum_q;
`endif
      // Zero and oversize lengths both mean "as long as allowed".
      len_eff    = (pkt_len == '0 || pkt_len > MAX_LEN) ? MAX_LEN : pkt_len;
      hs         = valid_q && m_axis.ready;
      final_beat = (cnt_q == len_q - ONE);

      case (state_q)
         IDLE: begin
            if (start) begin
               state_n = SEND;
               len_n   = len_eff;
               step_n  = step;
               data_n  = seed;
               cnt_n   = '0;
               valid_n = 1'b1;
               busy_n  = 1'b1;
`ifdef AXIS_PKT_GEN_CHECKSUM_EN
               last_n  = 1'b0;
               csum_n  = '0;
`else
               last_n  = (len_eff == ONE);
`endif
            end
         end
         SEND: begin
            if (hs) begin
`ifdef AXIS_PKT_GEN_CHECKSUM_EN
               csum_n = csum_q ^ data_q;
               if (final_beat) begin
                  // Trailing beat carries the running XOR including this word.
                  state_n = CSUM;
                  data_n  = csum_q ^ data_q;
                  last_n  = 1'b1;
               end else begin
                  cnt_n  = cnt_q + ONE;
                  data_n = data_q + step_q;
               end
`else
               if (final_beat) begin
                  state_n = DONE;
                  valid_n = 1'b0;
                  last_n  = 1'b0;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
                  pcnt_n  = pcnt_q + 1'b1;
               end else begin
                  cnt_n  = cnt_q + ONE;
                  data_n = data_q + step_q;
                  // Look one beat ahead so last is registered with its word.
                  last_n = ((cnt_q + ONE) == (len_q - ONE));
               end
`endif
            end
         end
`ifdef AXIS_PKT_GEN_CHECKSUM_EN
         CSUM: begin
            if (hs) begin
               state_n = DONE;
               valid_n = 1'b0;
               last_n  = 1'b0;
               busy_n  = 1'b0;
               done_n  = 1'b1;
               pcnt_n  = pcnt_q + 1'b1;
            end
         end
`endif
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge axi_clk) begin
      if (axi_reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
         step_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pcnt_q  <= '0;
`ifdef AXIS_PKT_GEN_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         len_q   <= len_n;
         step_q  <= step_n;
         data_q  <= data_n;
         valid_q <= valid_n;
         last_q  <= last_n;
         busy_q  <= busy_n;
         done_q  <= done_n;
         pcnt_q  <= pcnt_n;
`ifdef AXIS_PKT_GEN_CHECKSUM_EN
         csum_q  <= csum_n;
`endif
      end
   end

   assign m_axis.valid = valid_q;
   assign m_axis.data  = data_q;
   assign m_axis.last  = last_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign pkt_count    = pcnt_q;

endmodule
